gemm_seq_ctrl: RTL

//  Sequencer for the N x N weight-stationary systolic array of mac_units.

---
 rtl/npu_gemm_pkg.sv | 31 +++
 rtl/gemm_valid_pipe.sv | 26 ++
 rtl/gemm_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/npu_gemm_pkg.sv
// Shared types and sizing helpers for the GEMM sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package npu_gemm_pkg;

    localparam int DEF_ARRAY_N = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } gemm_state_e;

    // Cycles from an activation read strobe to its result row at the array edge
    function automatic int gemm_lat(int n, int rd_lat);
        return rd_lat + 2 * n;
    endfunction

    // Phase counter must hold the longest phase length without wrapping
    function automatic int gemm_cnt_w(int n, int m_w, int lat);
        int mx;
        mx = 2 * n;
        if ((1 << m_w) > mx) mx = 1 << m_w;
        if (lat > mx) mx = lat;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/gemm_valid_pipe.sv
// 1-bit delay line tracking which activation rows are still in flight.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; synchronous flush clears every stage at once.
module gemm_valid_pipe #(
    parameter int DEPTH = 9
) (
    input  logic clk,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    // Shift one stage per cycle; flush drops everything in flight
    always_ff @(posedge clk) begin
        if (flush) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/gemm_seq_ctrl.sv
// Tile sequencer for the weight-stationary systolic array: clear, weight load, stream, drain.
// Latency: outputs registered; a tile takes [1] + (2N-1) + M + (RD_LAT+2N) + 1 cycles after accept.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not latched.
module gemm_seq_ctrl
    import npu_gemm_pkg::*;
#(
    parameter int ARRAY_N = DEF_ARRAY_N,
    parameter int M_W     = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [M_W-1:0]               cmd_m,
    input  logic                         cmd_acc,
    input  logic                         abort,
    output logic                         wgt_rd_valid,
    output logic [$clog2(ARRAY_N)-1:0]   wgt_rd_addr,
    output logic                         act_rd_valid,
    output logic [M_W-1:0]               act_rd_addr,
    output logic                         mac_load_w,
    output logic                         mac_en,
    output logic                         mac_clr,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int LAT   = gemm_lat(ARRAY_N, RD_LAT);
    localparam int CNT_W = gemm_cnt_w(ARRAY_N, M_W, LAT);
    localparam int AW    = $clog2(ARRAY_N);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(2 * ARRAY_N - 2);
    localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(ARRAY_N - 1);
    localparam logic [CNT_W-1:0] WGT_NEXT  = CNT_W'(ARRAY_N - 2);
    localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(LAT - 1);

    gemm_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [M_W-1:0]   m_q;
    logic             pipe_flush;

    // Abort only matters mid-tile; reset always empties the delay line
    assign pipe_flush = rst | (abort & (state != IDLE));

    // Phase FSM: outputs are set on the edge that enters the cycle they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            m_q          <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            mac_clr      <= 1'b0;
            mac_load_w   <= 1'b0;
            mac_en       <= 1'b0;
            wgt_rd_valid <= 1'b0;
            wgt_rd_addr  <= '0;
            act_rd_valid <= 1'b0;
            act_rd_addr  <= '0;
        end else begin
            done         <= 1'b0;
            mac_clr      <= 1'b0;
            mac_load_w   <= 1'b0;
            mac_en       <= 1'b0;
            wgt_rd_valid <= 1'b0;
            act_rd_valid <= 1'b0;
            if (abort && state != IDLE) begin
                // Partial sums are garbage now, so wipe them on the way out
                state     <= IDLE;
                cnt       <= '0;
                mac_clr   <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            m_q       <= cmd_m;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            if (!cmd_acc) begin
                                state   <= CLR;
                                mac_clr <= 1'b1;
                            end else begin
                                state        <= LOAD_W;
                                mac_load_w   <= 1'b1;
                                wgt_rd_valid <= 1'b1;
                                wgt_rd_addr  <= AW'(ARRAY_N - 1);
                            end
                        end
                    end
                    CLR: begin
                        state        <= LOAD_W;
                        cnt          <= '0;
                        mac_load_w   <= 1'b1;
                        wgt_rd_valid <= 1'b1;
                        wgt_rd_addr  <= AW'(ARRAY_N - 1);
                    end
                    LOAD_W: begin
                        if (cnt == LOAD_LAST) begin
                            cnt <= '0;
                            if (m_q == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state        <= STREAM;
                                mac_en       <= 1'b1;
                                act_rd_valid <= 1'b1;
                                act_rd_addr  <= '0;
                            end
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            mac_load_w <= 1'b1;
                            // Weights enter farthest column first; the rest of the
                            // phase just shifts them into place
                            if (cnt < WGT_LAST) begin
                                wgt_rd_valid <= 1'b1;
                                wgt_rd_addr  <= AW'(WGT_NEXT - cnt);
                            end
                        end
                    end
                    STREAM: begin
                        mac_en <= 1'b1;
                        if (cnt == CNT_W'(m_q) - CNT_W'(1)) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt          <= cnt + CNT_W'(1);
                            act_rd_valid <= 1'b1;
                            act_rd_addr  <= M_W'(cnt + CNT_W'(1));
                        end
                    end
                    DRAIN: begin
                        if (cnt == DRN_LAST) begin
                            state <= DONE;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end else begin
                            cnt    <= cnt + CNT_W'(1);
                            mac_en <= 1'b1;
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    gemm_valid_pipe #(
        .DEPTH (LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .flush (pipe_flush),
        .din   (act_rd_valid),
        .dout  (out_valid)
    );

endmodule
